piece_mover: RTL and testbench

PIECE_MOVER -- requirements
Module: piece_mover

---
 rtl/piece_mover.sv | 204 ++++++++++++++++++++
 tb/tb_piece_mover.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_mover.sv
// -----------------------------------------------------------------------------
// piece_mover
//
// Moves the falling piece of a block-stacking game. Player requests and a
// frame-driven gravity timer propose a candidate position (CandX/CandY) to an
// external combinational boundary checker. The checker's verdict
// (legalX/legalY) either commits the candidate to the piece position
// (PieceX/PieceY) or rolls the candidate back. A refused downward move lands
// the piece: lock pulses, then spawn pulses, and a fresh piece appears at the
// spawn point.
//
// Parameters
//   SPAWN_X, SPAWN_Y : spawn coordinates in pixels
//   STEP             : move distance per request in pixels
//   GRAV_DIV         : frame_tick pulses per gravity drop (1..63)
//
// Ports
//   Clk                         in   system clock, rising edge
//   Reset_n                     in   asynchronous active-low reset
//   frame_tick                  in   one-cycle pulse per video frame
//   move_left/right/down        in   one-cycle player request pulses
//   legalX, legalY              in   checker verdict for CandX / CandY
//   CandX, CandY      [9:0]     out  candidate position shown to the checker
//   PieceX, PieceY    [9:0]     out  committed piece position
//   busy                        out  high whenever the FSM is not IDLE
//   lock                        out  one-cycle pulse when the piece lands
//   spawn                       out  one-cycle pulse when a new piece appears
//
// State table
//   state | meaning
//   IDLE  | waiting for a request; Cand mirrors Piece
//   CHECK | candidate on the checker, verdict applied this cycle
//   LOCK  | downward move refused, piece has landed
//   SPAWN | new piece placed at the spawn point, gravity timer restarted
// -----------------------------------------------------------------------------
module piece_mover #(
    parameter int SPAWN_X  = 320,
    parameter int SPAWN_Y  = 16,
    parameter int STEP     = 16,
    parameter int GRAV_DIV = 30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       move_down,
    input  logic       legalX,
    input  logic       legalY,
    output logic [9:0] CandX,
    output logic [9:0] CandY,
    output logic [9:0] PieceX,
    output logic [9:0] PieceY,
    output logic       busy,
    output logic       lock,
    output logic       spawn
);

    localparam logic [9:0] SPAWN_X_W = 10'(SPAWN_X);
    localparam logic [9:0] SPAWN_Y_W = 10'(SPAWN_Y);
    localparam logic [9:0] STEP_W    = 10'(STEP);
    localparam logic [5:0] GRAV_LAST = 6'(GRAV_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2,
        SPAWN = 2'd3
    } state_t;

    state_t     state;
    logic [5:0] grav_cnt;
    logic       grav_pend;
    logic       move_vert;   // kind of move held in CHECK: 1 = vertical

    logic       grav_expire;
    logic       pend_serviced;
    logic       req_vert;
    logic       req_left;
    logic       req_right;
    logic       left_ok;

    always_comb begin
        grav_expire   = 1'b0;
        pend_serviced = 1'b0;
        req_vert      = grav_pend | move_down;
        // Opposing horizontal pulses cancel each other out.
        req_left      = move_left & ~move_right;
        req_right     = move_right & ~move_left;
        // A left step from below STEP would wrap to the far right edge.
        left_ok       = (PieceX >= STEP_W);

        if (state != SPAWN && frame_tick && grav_cnt == GRAV_LAST)
            grav_expire = 1'b1;
        // Any vertical move taken from IDLE consumes a pending drop.
        if (state == IDLE && grav_pend)
            pend_serviced = 1'b1;
    end

    // Gravity divider. Freezes and clears while a new piece is spawning so the
    // fresh piece always gets a full GRAV_DIV period before its first drop.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
        end else if (state == SPAWN) begin
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
        end else begin
            if (frame_tick) begin
                if (grav_cnt == GRAV_LAST)
                    grav_cnt <= '0;
                else
                    grav_cnt <= grav_cnt + 6'd1;
            end
            // A fresh expiry in the same cycle a drop is serviced must not be
            // lost, so the set takes precedence over the clear.
            if (grav_expire)
                grav_pend <= 1'b1;
            else if (pend_serviced)
                grav_pend <= 1'b0;
        end
    end

    // Main sequencer with registered status outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            PieceX    <= SPAWN_X_W;
            PieceY    <= SPAWN_Y_W;
            CandX     <= SPAWN_X_W;
            CandY     <= SPAWN_Y_W;
            move_vert <= 1'b0;
            busy      <= 1'b0;
            lock      <= 1'b0;
            spawn     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_vert) begin
                        CandY     <= PieceY + STEP_W;
                        move_vert <= 1'b1;
                        state     <= CHECK;
                        busy      <= 1'b1;
                    end else if (req_left && left_ok) begin
                        CandX     <= PieceX - STEP_W;
                        move_vert <= 1'b0;
                        state     <= CHECK;
                        busy      <= 1'b1;
                    end else if (req_right) begin
                        CandX     <= PieceX + STEP_W;
                        move_vert <= 1'b0;
                        state     <= CHECK;
                        busy      <= 1'b1;
                    end
                end

                CHECK: begin
                    if (!move_vert) begin
                        if (legalX)
                            PieceX <= CandX;
                        else
                            CandX  <= PieceX;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (legalY) begin
                        PieceY <= CandY;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else begin
                        // Blocked going down: the piece has landed.
                        CandY <= PieceY;
                        state <= LOCK;
                        lock  <= 1'b1;
                    end
                end

                LOCK: begin
                    state <= SPAWN;
                    lock  <= 1'b0;
                    spawn <= 1'b1;
                end

                SPAWN: begin
                    PieceX <= SPAWN_X_W;
                    PieceY <= SPAWN_Y_W;
                    CandX  <= SPAWN_X_W;
                    CandY  <= SPAWN_Y_W;
                    state  <= IDLE;
                    spawn  <= 1'b0;
                    busy   <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    lock  <= 1'b0;
                    spawn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_mover.sv
module tb_piece_mover;

    localparam int GD   = 4;
    localparam int SX   = 320;
    localparam int SY   = 16;
    localparam int STP  = 16;

    logic       Clk;
    logic       Reset_n;
    logic       frame_tick, move_left, move_right, move_down, legalX, legalY;
    logic [9:0] CandX, CandY, PieceX, PieceY;
    logic       busy, lock, spawn;

    logic [9:0] CandX8, CandY8, PieceX8, PieceY8;
    logic       busy8, lock8, spawn8;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: piece position, candidate, gravity timer and the
    // current phase of the move sequence (0 idle, 1 checking, 2 landed,
    // 3 spawning).
    int m_px, m_py, m_cx, m_cy;
    int m_cnt;
    bit m_pend;
    bit m_vert;
    int m_phase;

    piece_mover #(.GRAV_DIV(GD)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .move_left(move_left), .move_right(move_right), .move_down(move_down),
        .legalX(legalX), .legalY(legalY),
        .CandX(CandX), .CandY(CandY), .PieceX(PieceX), .PieceY(PieceY),
        .busy(busy), .lock(lock), .spawn(spawn)
    );

    // Second instance spawning at x=8, used only for the left-edge drop case.
    piece_mover #(.SPAWN_X(8), .GRAV_DIV(GD)) dut8 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .move_left(move_left), .move_right(move_right), .move_down(move_down),
        .legalX(legalX), .legalY(legalY),
        .CandX(CandX8), .CandY(CandY8), .PieceX(PieceX8), .PieceY(PieceY8),
        .busy(busy8), .lock(lock8), .spawn(spawn8)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_px = SX; m_py = SY; m_cx = SX; m_cy = SY;
        m_cnt = 0; m_pend = 0; m_vert = 0; m_phase = 0;
    endtask

    task automatic model_step();
        bit expire;
        expire = 0;
        if (m_phase != 3 && frame_tick) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == GD) begin
                m_cnt  = 0;
                expire = 1;
            end
        end
        case (m_phase)
            0: begin
                if (m_pend || move_down) begin
                    m_vert = 1; m_cy = (m_py + STP) % 1024; m_pend = 0; m_phase = 1;
                end else if (move_left && !move_right) begin
                    if (m_px >= STP) begin
                        m_vert = 0; m_cx = m_px - STP; m_phase = 1;
                    end
                end else if (move_right && !move_left) begin
                    m_vert = 0; m_cx = (m_px + STP) % 1024; m_phase = 1;
                end
            end
            1: begin
                if (!m_vert) begin
                    if (legalX) m_px = m_cx; else m_cx = m_px;
                    m_phase = 0;
                end else if (legalY) begin
                    m_py = m_cy; m_phase = 0;
                end else begin
                    m_cy = m_py; m_phase = 2;
                end
            end
            2: m_phase = 3;
            default: begin
                m_px = SX; m_py = SY; m_cx = SX; m_cy = SY;
                m_cnt = 0; m_pend = 0; m_phase = 0;
            end
        endcase
        if (expire) m_pend = 1;
    endtask

    task automatic check_all();
        chk("PieceX", PieceX, m_px);
        chk("PieceY", PieceY, m_py);
        chk("CandX",  CandX,  m_cx);
        chk("CandY",  CandY,  m_cy);
        chk("busy",   busy,   (m_phase != 0));
        chk("lock",   lock,   (m_phase == 2));
        chk("spawn",  spawn,  (m_phase == 3));
    endtask

    task automatic cycle(input bit ft, input bit ml, input bit mr, input bit md,
                         input bit lx, input bit ly);
        frame_tick = ft; move_left = ml; move_right = mr; move_down = md;
        legalX = lx; legalY = ly;
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        check_all();
    endtask

    // Asynchronous reset pulse, checked before any clock edge can occur.
    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        chk("rst_PieceX", PieceX, SX);
        chk("rst_PieceY", PieceY, SY);
        chk("rst_CandX",  CandX,  SX);
        chk("rst_CandY",  CandY,  SY);
        chk("rst_busy",   busy,   0);
        chk("rst_lock",   lock,   0);
        chk("rst_spawn",  spawn,  0);
        #1;
        Reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        frame_tick = 0; move_left = 0; move_right = 0; move_down = 0;
        legalX = 0; legalY = 0;
        Reset_n = 1'b1;
        #2;
        do_reset();
        cycle(0, 0, 0, 0, 0, 0);

        // move_left refused by the checker; dut8 at x=8 drops the request.
        cycle(0, 1, 0, 0, 0, 0);
        chk("left_cand", CandX, 304);
        chk("left_busy", busy, 1);
        chk("edge8_busy", busy8, 0);
        chk("edge8_x", PieceX8, 8);
        cycle(0, 0, 0, 0, 0, 0);
        chk("left_rej_px", PieceX, 320);
        chk("left_rej_cx", CandX, 320);

        // move_right accepted.
        cycle(0, 0, 1, 0, 1, 0);
        chk("right_cand", CandX, 336);
        chk("right_busy", busy, 1);
        cycle(0, 0, 0, 0, 1, 0);
        chk("right_px", PieceX, 336);
        chk("right_idle", busy, 0);

        // Both horizontal pulses together: ignored.
        cycle(0, 1, 1, 0, 1, 1);
        chk("both_busy", busy, 0);
        chk("both_px", PieceX, 336);

        // Gravity after GD frame ticks.
        for (int i = 0; i < GD; i++) cycle(1, 0, 0, 0, 1, 1);
        chk("grav_wait", busy, 0);
        cycle(0, 0, 0, 0, 1, 1);
        chk("grav_cand", CandY, 32);
        cycle(0, 0, 0, 0, 1, 1);
        chk("grav_py", PieceY, 32);

        // Gravity expiry while in CHECK, serviced at the first IDLE cycle.
        for (int i = 0; i < GD - 1; i++) cycle(1, 0, 0, 0, 1, 1);
        cycle(0, 0, 1, 0, 1, 1);
        cycle(1, 0, 0, 0, 1, 1);
        chk("chk_exp_px", PieceX, 352);
        chk("chk_exp_idle", busy, 0);
        cycle(0, 0, 0, 0, 1, 1);
        chk("pend_cand", CandY, 48);
        chk("pend_busy", busy, 1);
        cycle(0, 0, 0, 0, 1, 1);

        // Landing: lock then spawn, ticks during LOCK/SPAWN.
        for (int i = 0; i < GD; i++) cycle(1, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("land_lock", lock, 1);
        chk("land_py", PieceY, 48);
        cycle(1, 0, 0, 0, 1, 0);
        chk("land_spawn", spawn, 1);
        chk("land_unlock", lock, 0);
        cycle(1, 0, 0, 0, 1, 0);
        chk("spawn_x", PieceX, 320);
        chk("spawn_y", PieceY, 16);
        chk("spawn_done", spawn, 0);
        for (int i = 0; i < GD - 1; i++) cycle(1, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        chk("cnt_cleared", busy, 0);
        cycle(1, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        chk("cnt_full", busy, 1);
        cycle(0, 0, 0, 0, 1, 1);

        // Walk to the left edge, then a further left is dropped.
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 0, 0, 1, 1);
            cycle(0, 0, 0, 0, 1, 1);
        end
        chk("edge_px", PieceX, 0);
        cycle(0, 1, 0, 0, 1, 1);
        chk("edge_drop", busy, 0);

        // Reset while in CHECK.
        cycle(0, 0, 1, 0, 1, 1);
        chk("mid_chk_busy", busy, 1);
        do_reset();
        cycle(0, 0, 0, 0, 1, 1);

        // Reset while in LOCK.
        for (int i = 0; i < GD; i++) cycle(1, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("pre_rst_lock", lock, 1);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
